axis_pkt_route_merge: RTL and testbench
=======================================

Name: axis_pkt_route_merge

Overview:
- Packet-granular AXI-stream routing fabric with two independent halves.
- Split half: steers one slave stream to one of NUM master streams, chosen by an address sampled on each packet's first beat.
- Merge half: arbitrates NUM slave streams onto one master stream, locking the grant for a whole packet.
- Sits between pipeline stages in header-cut/append datapaths, which route packets to alternate processing branches and recombine them.

Parameters:
- NUM, 3, number of split outputs and merge inputs (2..16).
- DSIZE, 8, tdata width in bits.
- AW, $clog2(NUM) (minimum 1), route address width.

Ports:
- clock  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- route_addr  in  AW  split destination; sampled on a packet's first beat.
- s_tdata  in  DSIZE  split slave data.
- s_tuser  in  1  split slave user bit.
- s_tvalid  in  1  split slave valid.
- s_tlast  in  1  split slave end of packet.
- s_tready  out  1  split slave ready.
- m_tdata  out  NUM*DSIZE  split master data, one DSIZE slice per port i.
- m_tuser  out  NUM  split master user bits.
- m_tvalid  out  NUM  split master valids.
- m_tlast  out  NUM  split master end-of-packet flags.
- m_tready  in  NUM  split master readies.
- c_tdata  in  NUM*DSIZE  merge slave data.
- c_tuser  in  NUM  merge slave user bits.
- c_tvalid  in  NUM  merge slave valids.
- c_tlast  in  NUM  merge slave end-of-packet flags.
- c_tready  out  NUM  merge slave readies.
- o_tdata  out  DSIZE  merge master data.
- o_tuser  out  1  merge master user bit.
- o_tvalid  out  1  merge master valid.
- o_tlast  out  1  merge master end of packet.
- o_tready  in  1  merge master ready.

Behaviour:
- Handshake on any link = tvalid && tready on the same rising clock edge. No combinational path from any tready back to the same link's tvalid.
- Reset values:
  - split in_pkt = 0, latched address = 0.
  - merge lock = 0, grant = 0, rr pointer = NUM-1.
  - Therefore all m_tvalid = 0, o_tvalid = 0, c_tready = 0.
- Split half:
  - sel = in_pkt ? addr_q : route_addr.
  - On s_tvalid && !in_pkt, route_addr is used combinationally, giving zero latency.
  - On the first-beat handshake without tlast: addr_q <= route_addr, in_pkt <= 1.
  - On a tlast handshake: in_pkt <= 0.
  - A one-beat packet (tlast on first beat) leaves in_pkt at 0.
  - Mid-packet route_addr changes are ignored.
  - m_tvalid[i] = s_tvalid && (sel == i). m_tdata, m_tuser and m_tlast are broadcast to every slice. s_tready = m_tready[sel].
  - If sel >= NUM, the packet is discarded: s_tready = 1, all m_tvalid = 0, whole packet consumed through tlast.
- Merge half:
  - States: IDLE (lock = 0) and LOCKED (lock = 1, grant).
  - IDLE: if any c_tvalid is set, grant <= first index with c_tvalid set, searching upward from rr+1 and wrapping; lock <= 1. The winner starts transferring the following cycle (1-cycle arbitration latency).
  - LOCKED: o_* = c_*[grant]; o_tvalid = c_tvalid[grant]; c_tready[grant] = o_tready; other c_tready = 0.
  - On a c_tlast[grant] handshake: lock <= 0, rr <= grant. The next arbitration happens the following cycle, so there is exactly one idle cycle between packets even when requests are pending.
  - While IDLE: o_tvalid = 0 and all c_tready = 0.
  - c_tvalid dropping while LOCKED does not release the lock.
- rst_n asserted mid-packet: both halves return to reset state immediately. Partial packets are abandoned; no recovery of stream alignment is attempted.

Optional Feature:
- Macro AXIS_MERGE_FIXED_PRIO_EN.
- Defined: merge arbitration is fixed priority, lowest asserted c_tvalid index wins, rr pointer unused.
- Undefined: round-robin as described in Behaviour.
- Split half is identical in both builds.

Test Plan:
- Split routing: route_addr = 2 on first beat, then changed to 0 mid-packet, 4-beat packet 0x11..0x44 -> only m_tvalid[2] asserted for all 4 beats; tlast on 0x44; in_pkt = 0 afterwards.
- Split back-pressure: m_tready[1] = 0 for 3 cycles with addr 1 -> s_tready = 0 and data held; resume -> every beat delivered once, in order.
- Split drop: NUM = 3, route_addr = 3, 2-beat packet -> s_tready = 1 each cycle, no m_tvalid asserted; next packet with addr 0 routes normally.
- Merge round-robin: c_tvalid = 3'b111, each input sending 2-beat packets -> output order 0, 1, 2, 0; one o_tvalid = 0 cycle between packets.
- Merge lock: input 1 granted, input 0 asserts mid-packet -> input 1 packet completes uninterrupted; input 0 granted after the gap; with AXIS_MERGE_FIXED_PRIO_EN and all inputs valid, input 0 is always chosen.
- Reset mid-packet on both halves -> all valids and readys are 0 one cycle after assertion; a clean packet after deassertion routes by fresh route_addr.

Source files
------------

// File: rtl/axis_pkt_route_merge_if.sv
// AXI-stream bundle of LANES parallel links sharing one DSIZE-wide slice each.
// master drives payload/valid and receives ready; slave is the mirror image.
interface axis_pkt_route_merge_if #(
  parameter int LANES = 1,
  parameter int DSIZE = 8
);
  logic [LANES*DSIZE-1:0] tdata;
  logic [LANES-1:0]       tuser;
  logic [LANES-1:0]       tvalid;
  logic [LANES-1:0]       tlast;
  logic [LANES-1:0]       tready;

  modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_route_merge.sv
// Packet-granular AXI-stream split (1->NUM by first-beat address) and merge (NUM->1, packet-locked).
// Optional macro AXIS_MERGE_FIXED_PRIO_EN: merge uses fixed priority (lowest index) instead of round-robin.
module axis_pkt_route_merge #(
  parameter int NUM   = 3,
  parameter int DSIZE = 8,
  parameter int AW    = (NUM > 2) ? $clog2(NUM) : 1
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic [AW-1:0]           route_addr,
  axis_pkt_route_merge_if.slave   s,
  axis_pkt_route_merge_if.master  m,
  axis_pkt_route_merge_if.slave   c,
  axis_pkt_route_merge_if.master  o
);

  // ---------------- split half ----------------
  logic          r_in_pkt;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_sel;
  logic          w_sel_ok;
  logic          w_s_hs;

  assign w_sel    = r_in_pkt ? r_addr : route_addr;
  assign w_sel_ok = (int'(w_sel) < NUM);
  // Out-of-range destinations are swallowed so a bad address cannot stall the source.
  assign s.tready = w_sel_ok ? m.tready[w_sel] : 1'b1;
  assign w_s_hs   = s.tvalid[0] && s.tready[0];

  assign m.tdata  = {NUM{s.tdata}};
  assign m.tuser  = {NUM{s.tuser}};
  assign m.tlast  = {NUM{s.tlast}};

  always_comb begin
    m.tvalid = '0;
    for (int i = 0; i < NUM; i++) begin
      m.tvalid[i] = s.tvalid[0] && (int'(w_sel) == i);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_in_pkt <= 1'b0;
      r_addr   <= '0;
    end else if (w_s_hs) begin
      if (s.tlast[0]) begin
        r_in_pkt <= 1'b0;
      end else if (!r_in_pkt) begin
        r_in_pkt <= 1'b1;
        r_addr   <= route_addr;
      end
    end
  end

  // ---------------- merge half ----------------
  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t        r_state;
  logic [AW-1:0] r_grant;
  logic          w_locked;
  logic          w_found;
  logic [AW-1:0] w_pick;
  logic          w_end;
`ifndef AXIS_MERGE_FIXED_PRIO_EN
  logic [AW-1:0] r_rr;
`endif

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
`ifdef AXIS_MERGE_FIXED_PRIO_EN
    for (int k = 0; k < NUM; k++) begin
      if (!w_found && c.tvalid[k]) begin
        w_found = 1'b1;
        w_pick  = AW'(k);
      end
    end
`else
    // Search starts just after the last winner and wraps.
    for (int k = 1; k <= NUM; k++) begin
      if (!w_found && c.tvalid[(int'(r_rr) + k) % NUM]) begin
        w_found = 1'b1;
        w_pick  = AW'((int'(r_rr) + k) % NUM);
      end
    end
`endif
  end

  assign w_locked = (r_state == ST_LOCKED);
  assign o.tvalid = w_locked && c.tvalid[r_grant];
  assign o.tdata  = c.tdata[int'(r_grant)*DSIZE +: DSIZE];
  assign o.tuser  = c.tuser[r_grant];
  assign o.tlast  = c.tlast[r_grant];
  assign w_end    = o.tvalid[0] && o.tready[0] && o.tlast[0];

  always_comb begin
    c.tready = '0;
    for (int i = 0; i < NUM; i++) begin
      c.tready[i] = w_locked && (int'(r_grant) == i) && o.tready[0];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
`ifndef AXIS_MERGE_FIXED_PRIO_EN
      r_rr    <= AW'(NUM - 1);
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // Release only on the final beat; a source dropping valid keeps its grant.
          if (w_end) begin
            r_state <= ST_IDLE;
`ifndef AXIS_MERGE_FIXED_PRIO_EN
            r_rr    <= r_grant;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_route_merge.sv
// Directed self-checking bench for axis_pkt_route_merge (NUM=3, DSIZE=8).
// Honours AXIS_MERGE_FIXED_PRIO_EN for the merge ordering expectations.
module tb_axis_pkt_route_merge;
  localparam int NUM   = 3;
  localparam int DSIZE = 8;

  localparam logic [2:0] LK_REQ [9] = '{3'b010, 3'b011, 3'b011, 3'b011, 3'b001,
                                        3'b001, 3'b001, 3'b001, 3'b000};
  localparam logic [7:0] LK_D   [9] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h00,
                                        8'h00, 8'h01, 8'h02, 8'h00};
  localparam logic [2:0] LK_CR  [9] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000,
                                        3'b001, 3'b001, 3'b001, 3'b000};
  localparam logic [8:0] LK_V = 9'b011101110;
  localparam logic [8:0] LK_L = 9'b010001000;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [1:0] route_addr;

  always #5 clock = ~clock;

  axis_pkt_route_merge_if #(.LANES(1),   .DSIZE(DSIZE)) s_if ();
  axis_pkt_route_merge_if #(.LANES(NUM), .DSIZE(DSIZE)) m_if ();
  axis_pkt_route_merge_if #(.LANES(NUM), .DSIZE(DSIZE)) c_if ();
  axis_pkt_route_merge_if #(.LANES(1),   .DSIZE(DSIZE)) o_if ();

  axis_pkt_route_merge #(.NUM(NUM), .DSIZE(DSIZE)) u_dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .route_addr (route_addr),
    .s          (s_if),
    .m          (m_if),
    .c          (c_if),
    .o          (o_if)
  );

  int checks = 0;
  int errors = 0;
  int cnt [NUM];
  int plen = 2;

  logic        obs_ov, obs_ol, obs_sr;
  logic [7:0]  obs_od;
  logic [2:0]  obs_cr, obs_mv, obs_ml;
  logic [23:0] obs_md;

  task automatic drive_merge(input logic [2:0] req);
    c_if.tvalid = req;
    for (int i = 0; i < NUM; i++) begin
      c_if.tdata[i*8 +: 8] = 8'(i*16 + cnt[i]);
      c_if.tlast[i]        = ((cnt[i] % plen) == plen - 1);
      c_if.tuser[i]        = 1'b0;
    end
  endtask

  // Sample all outputs mid-cycle, then advance merge sources that handshook.
  task automatic cycle();
    @(negedge clock);
    obs_ov = o_if.tvalid[0];
    obs_ol = o_if.tlast[0];
    obs_od = o_if.tdata;
    obs_cr = c_if.tready;
    obs_mv = m_if.tvalid;
    obs_ml = m_if.tlast;
    obs_md = m_if.tdata;
    obs_sr = s_if.tready[0];
    @(posedge clock);
    for (int i = 0; i < NUM; i++) begin
      if (c_if.tvalid[i] && obs_cr[i] && o_if.tready[0]) cnt[i]++;
    end
    #1;
  endtask

  task automatic reset_cnt();
    for (int i = 0; i < NUM; i++) cnt[i] = 0;
  endtask

  task automatic test_reset();
    reset_cnt();
    drive_merge(3'b111);
    cycle();
    checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_o_tvalid: got %b expected 0", obs_ov); end
    checks++; if (obs_cr !== 3'b000) begin errors++; $display("FAIL reset_c_tready: got %b expected 000", obs_cr); end
    checks++; if (obs_mv !== 3'b000) begin errors++; $display("FAIL reset_m_tvalid: got %b expected 000", obs_mv); end
    drive_merge(3'b000);
    rst_n = 1'b1;
    cycle();
    checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_idle_o_tvalid: got %b expected 0", obs_ov); end
  endtask

  task automatic test_split_route();
    logic [7:0] d;
    m_if.tready = 3'b111;
    for (int k = 0; k < 4; k++) begin
      d = 8'(17 * (k + 1));
      route_addr    = (k == 0) ? 2'd2 : 2'd0;
      s_if.tvalid   = 1'b1;
      s_if.tdata    = d;
      s_if.tlast    = (k == 3);
      cycle();
      checks++; if (obs_mv !== 3'b100) begin errors++; $display("FAIL route_m_tvalid beat %0d: got %b expected 100", k, obs_mv); end
      checks++; if (obs_sr !== 1'b1) begin errors++; $display("FAIL route_s_tready beat %0d: got %b expected 1", k, obs_sr); end
      checks++; if (obs_md[23:16] !== d) begin errors++; $display("FAIL route_data beat %0d: got %h expected %h", k, obs_md[23:16], d); end
      checks++; if (obs_ml !== ((k == 3) ? 3'b111 : 3'b000)) begin errors++; $display("FAIL route_tlast beat %0d: got %b", k, obs_ml); end
    end
    route_addr = 2'd1;
    s_if.tdata = 8'h55;
    s_if.tlast = 1'b1;
    cycle();
    checks++; if (obs_mv !== 3'b010) begin errors++; $display("FAIL route_after_pkt: got %b expected 010", obs_mv); end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_split_backpressure();
    logic [7:0] d;
    m_if.tready = 3'b101;
    route_addr  = 2'd1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hA1;
    s_if.tlast  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++; if (obs_sr !== 1'b0) begin errors++; $display("FAIL bp_stall_ready cyc %0d: got %b expected 0", k, obs_sr); end
      checks++; if (obs_mv !== 3'b010 || obs_md[15:8] !== 8'hA1) begin errors++; $display("FAIL bp_stall_hold cyc %0d: got %b/%h expected 010/a1", k, obs_mv, obs_md[15:8]); end
    end
    m_if.tready = 3'b111;
    for (int b = 0; b < 3; b++) begin
      d = 8'(8'hA1 + b);
      s_if.tdata = d;
      s_if.tlast = (b == 2);
      if (b > 0) route_addr = 2'd0;
      cycle();
      checks++; if (obs_sr !== 1'b1) begin errors++; $display("FAIL bp_resume_ready beat %0d: got %b expected 1", b, obs_sr); end
      checks++; if (obs_mv !== 3'b010 || obs_md[15:8] !== d) begin errors++; $display("FAIL bp_resume_data beat %0d: got %b/%h expected 010/%h", b, obs_mv, obs_md[15:8], d); end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_split_drop();
    m_if.tready = 3'b000;
    route_addr  = 2'd3;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hD0;
    s_if.tlast  = 1'b0;
    cycle();
    checks++; if (obs_sr !== 1'b1 || obs_mv !== 3'b000) begin errors++; $display("FAIL drop_beat0: got ready %b valid %b expected 1/000", obs_sr, obs_mv); end
    route_addr = 2'd0;
    s_if.tdata = 8'hD1;
    s_if.tlast = 1'b1;
    cycle();
    checks++; if (obs_sr !== 1'b1 || obs_mv !== 3'b000) begin errors++; $display("FAIL drop_beat1: got ready %b valid %b expected 1/000", obs_sr, obs_mv); end
    m_if.tready = 3'b111;
    s_if.tdata  = 8'h5A;
    cycle();
    checks++; if (obs_mv !== 3'b001 || obs_md[7:0] !== 8'h5A) begin errors++; $display("FAIL drop_next_pkt: got %b/%h expected 001/5a", obs_mv, obs_md[7:0]); end
    s_if.tvalid = 1'b0;
  endtask

  task automatic test_merge_rr();
    int pk, ph, src, base;
    logic [7:0] ed;
    reset_cnt();
    plen = 2;
    for (int t = 0; t < 12; t++) begin
      drive_merge(3'b111);
      cycle();
      pk = t / 3;
      ph = t % 3;
`ifdef AXIS_MERGE_FIXED_PRIO_EN
      src  = 0;
      base = pk * 2;
`else
      src  = pk % 3;
      base = (pk / 3) * 2;
`endif
      ed = 8'(src*16 + base + ph - 1);
      checks++; if (obs_ov !== (ph != 0)) begin errors++; $display("FAIL rr_valid cyc %0d: got %b expected %b", t, obs_ov, (ph != 0)); end
      if (ph != 0) begin
        checks++; if (obs_od !== ed || obs_ol !== (ph == 2)) begin errors++; $display("FAIL rr_data cyc %0d: got %h/%b expected %h/%b", t, obs_od, obs_ol, ed, (ph == 2)); end
      end
    end
  endtask

  task automatic test_merge_lock();
    reset_cnt();
    plen = 3;
    for (int t = 0; t < 9; t++) begin
      drive_merge(LK_REQ[t]);
      cycle();
      checks++; if (obs_ov !== LK_V[t]) begin errors++; $display("FAIL lock_valid cyc %0d: got %b expected %b", t, obs_ov, LK_V[t]); end
      checks++; if (obs_cr !== LK_CR[t]) begin errors++; $display("FAIL lock_ready cyc %0d: got %b expected %b", t, obs_cr, LK_CR[t]); end
      if (LK_V[t]) begin
        checks++; if (obs_od !== LK_D[t] || obs_ol !== LK_L[t]) begin errors++; $display("FAIL lock_data cyc %0d: got %h/%b expected %h/%b", t, obs_od, obs_ol, LK_D[t], LK_L[t]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset_cnt();
    plen = 2;
    m_if.tready = 3'b111;
    route_addr  = 2'd2;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h77;
    s_if.tlast  = 1'b0;
    drive_merge(3'b100);
    cycle();
    checks++; if (obs_mv !== 3'b100 || obs_ov !== 1'b0) begin errors++; $display("FAIL mid_start: got %b/%b expected 100/0", obs_mv, obs_ov); end
    route_addr = 2'd1;
    s_if.tdata = 8'h78;
    drive_merge(3'b100);
    cycle();
    checks++; if (obs_mv !== 3'b100 || obs_ov !== 1'b1 || obs_od !== 8'h20) begin errors++; $display("FAIL mid_inflight: got %b/%b/%h expected 100/1/20", obs_mv, obs_ov, obs_od); end
    rst_n      = 1'b0;
    route_addr = 2'd3;
    drive_merge(3'b100);
    cycle();
    checks++; if (obs_mv !== 3'b000) begin errors++; $display("FAIL mid_rst_m_tvalid: got %b expected 000", obs_mv); end
    checks++; if (obs_ov !== 1'b0 || obs_cr !== 3'b000) begin errors++; $display("FAIL mid_rst_merge: got %b/%b expected 0/000", obs_ov, obs_cr); end
    s_if.tvalid = 1'b0;
    drive_merge(3'b000);
    rst_n = 1'b1;
    reset_cnt();
    route_addr  = 2'd1;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'h99;
    s_if.tlast  = 1'b1;
    drive_merge(3'b011);
    cycle();
    checks++; if (obs_mv !== 3'b010 || obs_md[15:8] !== 8'h99 || obs_ov !== 1'b0) begin errors++; $display("FAIL post_rst_split: got %b/%h/%b expected 010/99/0", obs_mv, obs_md[15:8], obs_ov); end
    s_if.tvalid = 1'b0;
    drive_merge(3'b011);
    cycle();
    checks++; if (obs_ov !== 1'b1 || obs_od !== 8'h00 || obs_cr !== 3'b001) begin errors++; $display("FAIL post_rst_merge: got %b/%h/%b expected 1/00/001", obs_ov, obs_od, obs_cr); end
  endtask

  initial begin
    rst_n        = 1'b0;
    route_addr   = 2'd0;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tuser   = '0;
    s_if.tlast   = 1'b0;
    m_if.tready  = '0;
    o_if.tready  = 1'b1;
    c_if.tvalid  = '0;
    c_if.tdata   = '0;
    c_if.tuser   = '0;
    c_if.tlast   = '0;
    test_reset();
    test_split_route();
    test_split_backpressure();
    test_split_drop();
    test_merge_rr();
    test_merge_lock();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
